// File: rtl/nfu_accum_pkg.sv
// Shared NFU definitions: default widths, accumulator FSM encoding and
// saturation limits for the default result width.
package nfu_accum_pkg;

  localparam int NFU_N     = 16;
  localparam int NFU_ACC_W = 24;
  localparam int NFU_LEN_W = 8;

  localparam logic [NFU_N-1:0] NFU_SAT_MAX = {1'b0, {(NFU_N-1){1'b1}}};
  localparam logic [NFU_N-1:0] NFU_SAT_MIN = {1'b1, {(NFU_N-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/nfu_accum_sat.sv
// Combinational ACC_W-to-N signed saturator; zero latency, no flow control.
// Shared by the accumulator and the adder-tree stage.
module nfu_sat
  import nfu_accum_pkg::*;
#(
  parameter int ACC_W = NFU_ACC_W,
  parameter int N     = NFU_N
) (
  input  logic [ACC_W-1:0] acc_in,
  output logic [N-1:0]     sat_out
);

  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  logic [ACC_W-N:0] top_bits;
  logic             fits;

  // The value fits in N bits when every bit from the N-bit sign position up matches.
  assign top_bits = acc_in[ACC_W-1:N-1];
  assign fits     = (&top_bits) || !(|top_bits);

  always_comb begin
    sat_out = acc_in[N-1:0];
    if (!fits) begin
      sat_out = acc_in[ACC_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/nfu_accum.sv
// Sums len signed products per neuron in a wrapping ACC_W accumulator and saturates to N bits.
// Result valid the cycle after the last product; in_ready is low while idle or holding a result.
module nfu_accum
  import nfu_accum_pkg::*;
#(
  parameter int N     = NFU_N,
  parameter int ACC_W = NFU_ACC_W,
  parameter int LEN_W = NFU_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [N-1:0]     prod_in,
  input  logic             prod_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [LEN_W-1:0] cnt;
  logic [N-1:0]     sat_val;
  logic             prod_take;
  logic             last_prod;
  logic             start_take;

  assign in_ready  = (state == ST_ACCUM);
  assign busy      = (state != ST_IDLE);
  assign prod_take = prod_valid && in_ready;
  assign last_prod = prod_take && (cnt == LEN_W'(1));
  assign acc_sum   = acc + {{(ACC_W-N){prod_in[N-1]}}, prod_in};

  // A result handshake and a new start in the same cycle chain without a bubble.
  assign start_take = start && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));

  nfu_sat #(
    .ACC_W (ACC_W),
    .N     (N)
  ) u_sat (
    .acc_in  (acc_sum),
    .sat_out (sat_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (prod_take) begin
            acc <= acc_sum;
            cnt <= cnt - LEN_W'(1);
          end
          if (last_prod) begin
            out_data  <= sat_val;
            out_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: ;
      endcase

      if (start_take) begin
        if (len != '0) begin
          acc   <= '0;
          cnt   <= len;
          state <= ST_ACCUM;
        end else begin
          out_data  <= '0;
          out_valid <= 1'b1;
          state     <= ST_HOLD;
        end
      end
    end
  end

endmodule

// File: tb/tb_nfu_accum.sv
// Randomized bench for nfu_accum: products are summed as plain integers, wrapped
// to ACC_W and clamped to N bits, then compared with the DUT result.
module tb_nfu_accum;
  import nfu_accum_pkg::*;

  localparam int N     = 16;
  localparam int ACC_W = 24;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [N-1:0]     prod_in;
  logic             prod_valid;
  logic             in_ready;
  logic [N-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Entry bit 16 marks a valid product; 0 means a bubble cycle.
  logic [16:0] stim_q[$];

  always #5 clk = ~clk;

  nfu_accum #(
    .N     (N),
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .prod_in    (prod_in),
    .prod_valid (prod_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] ref_result(input longint sum);
    longint w;
    w = sum & ((longint'(1) << ACC_W) - 1);
    if (w >= (longint'(1) << (ACC_W-1))) w = w - (longint'(1) << ACC_W);
    if (w > 32767)  w = 32767;
    if (w < -32768) w = -32768;
    return N'(w);
  endfunction

  function automatic logic [N-1:0] rand_prod();
    case ($urandom_range(0, 4))
      0:       return N'(int'($urandom_range(0, 200)) - 100);
      1:       return N'($urandom);
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return N'($urandom_range(16'h7000, 16'h7FFF));
    endcase
  endfunction

  task automatic push_p(input logic [N-1:0] p);
    stim_q.push_back({1'b1, p});
  endtask

  task automatic push_b();
    stim_q.push_back({1'b0, 16'hDEAD});
  endtask

  task automatic gen_random(input int l);
    stim_q.delete();
    for (int k = 0; k < l; k++) begin
      if ($urandom_range(0, 3) == 0) push_b();
      push_p(rand_prod());
    end
  endtask

  // Issues start (optionally together with the result handshake) and checks the entry state.
  task automatic start_neuron(input int l, input bit hs);
    start      = 1'b1;
    len        = LEN_W'(l);
    out_ready  = hs;
    prod_valid = 1'($urandom_range(0, 1));
    prod_in    = N'($urandom);
    step();
    start      = 1'b0;
    out_ready  = 1'b0;
    prod_valid = 1'b0;
    if (l != 0) begin
      check_eq("start_in_ready", in_ready, 1);
      check_eq("start_out_valid", out_valid, 0);
    end else begin
      check_eq("len0_out_valid", out_valid, 1);
      check_eq("len0_out_data", out_data, 0);
      check_eq("len0_in_ready", in_ready, 0);
    end
    check_eq("start_busy", busy, 1);
  endtask

  // Plays stim_q into the accumulator; noise asserts start on every bubble.
  task automatic feed(input bit noise, output logic [N-1:0] exp);
    longint      sum = 0;
    logic [16:0] e;
    while (stim_q.size() > 0) begin
      e = stim_q.pop_front();
      check_eq("accum_in_ready", in_ready, 1);
      check_eq("accum_out_valid", out_valid, 0);
      prod_valid = e[16];
      prod_in    = e[15:0];
      start      = noise && !e[16];
      len        = LEN_W'($urandom_range(1, 3));
      out_ready  = 1'($urandom_range(0, 1));
      if (e[16]) sum += longint'($signed(e[15:0]));
      step();
    end
    prod_valid = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b0;
    exp        = ref_result(sum);
    check_eq("result_valid", out_valid, 1);
    check_eq("result_data", out_data, exp);
    check_eq("result_in_ready", in_ready, 0);
  endtask

  task automatic hold(input int cycles, input logic [N-1:0] exp);
    for (int c = 0; c < cycles; c++) begin
      out_ready  = 1'b0;
      prod_valid = 1'($urandom_range(0, 1));
      prod_in    = N'($urandom);
      start      = 1'($urandom_range(0, 1));
      len        = LEN_W'($urandom);
      step();
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_data", out_data, exp);
      check_eq("hold_in_ready", in_ready, 0);
    end
    prod_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("release_valid", out_valid, 0);
    check_eq("release_busy", busy, 0);
    check_eq("release_in_ready", in_ready, 0);
  endtask

  task automatic idle_noise(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      prod_valid = 1'b1;
      prod_in    = N'($urandom);
      step();
      check_eq("idle_in_ready", in_ready, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_out_valid", out_valid, 0);
    end
    prod_valid = 1'b0;
  endtask

  task automatic end_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp;
    bit           pending;
    int           l;

    rst = 1'b1; start = 1'b0; len = '0; prod_in = '0; prod_valid = 1'b0; out_ready = 1'b0;
    #3;
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_out_data", out_data, 0);
    check_eq("reset_in_ready", in_ready, 0);
    check_eq("reset_busy", busy, 0);
    repeat (2) @(posedge clk);
    end_reset();
    idle_noise(2);

    // Basic sum
    start_neuron(4, 0);
    stim_q.delete(); push_p(1); push_p(2); push_p(3); push_p(4);
    feed(0, exp);
    check_eq("basic_sum", out_data, 10);
    release_result();

    // Bubbles and negatives
    start_neuron(3, 0);
    stim_q.delete(); push_p(-16'sd5); push_b(); push_b(); push_p(7); push_p(-16'sd1);
    feed(0, exp);
    check_eq("neg_sum", out_data, 1);
    release_result();

    // Saturation both ways
    start_neuron(3, 0);
    stim_q.delete(); repeat (3) push_p(16'h7000);
    feed(0, exp);
    check_eq("sat_pos", out_data, 16'h7FFF);
    release_result();
    start_neuron(2, 0);
    stim_q.delete(); repeat (2) push_p(16'h8000);
    feed(0, exp);
    check_eq("sat_neg", out_data, 16'h8000);
    release_result();

    // Backpressure then back-to-back
    start_neuron(2, 0);
    stim_q.delete(); push_p(10); push_p(20);
    feed(0, exp);
    hold(5, 16'd30);
    start_neuron(2, 1);
    stim_q.delete(); push_p(3); push_p(3);
    feed(0, exp);
    check_eq("b2b_sum", out_data, 6);
    release_result();

    // len=0 and start ignored during ACCUM
    start_neuron(0, 0);
    release_result();
    start_neuron(3, 0);
    stim_q.delete(); push_p(5); push_b(); push_b(); push_p(6); push_p(7);
    feed(1, exp);
    check_eq("ignored_start_sum", out_data, 18);
    release_result();

    // Reset while holding a result
    start_neuron(1, 0);
    stim_q.delete(); push_p(16'h1234);
    feed(0, exp);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_hold_out_valid", out_valid, 0);
    check_eq("rst_hold_out_data", out_data, 0);
    check_eq("rst_hold_busy", busy, 0);
    end_reset();

    // Reset mid-accumulation
    start_neuron(4, 0);
    prod_valid = 1'b1; prod_in = 16'd100; step();
    prod_in = 16'd200; step();
    prod_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_in_ready", in_ready, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_out_valid", out_valid, 0);
    check_eq("rst_mid_out_data", out_data, 0);
    end_reset();
    start_neuron(1, 0);
    stim_q.delete(); push_p(9);
    feed(0, exp);
    check_eq("post_rst_sum", out_data, 9);
    release_result();

    // Randomized neurons
    pending = 1'b0;
    for (int i = 0; i < 40; i++) begin
      l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      if (pending && ($urandom_range(0, 1) == 1)) begin
        start_neuron(l, 1);
      end else begin
        if (pending) release_result();
        idle_noise(int'($urandom_range(0, 2)));
        start_neuron(l, 0);
      end
      if (l != 0) begin
        gen_random(l);
        feed(1'($urandom_range(0, 1)), exp);
      end else begin
        exp = '0;
      end
      hold(int'($urandom_range(0, 3)), exp);
      pending = 1'b1;
    end
    if (pending) release_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
